// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory bus: byte address, lane-aligned write data with per-byte
// enables, read enable, combinational read data, timer interrupt level and a
// one-cycle bus-error pulse for unmapped accesses.
//   master : core side, drives the request and samples the responses
//   slave  : responder side, samples the request and drives the responses
interface data_mem_responder_if;

    logic [31:0] i_DM_addr;
    logic [31:0] i_DM_wd;
    logic [3:0]  i_DM_wen;
    logic        i_DM_ren;
    logic [31:0] o_DM_rd;
    logic        o_timer_irq;
    logic        o_bus_err;

    modport master (
        output i_DM_addr,
        output i_DM_wd,
        output i_DM_wen,
        output i_DM_ren,
        input  o_DM_rd,
        input  o_timer_irq,
        input  o_bus_err
    );

    modport slave (
        input  i_DM_addr,
        input  i_DM_wd,
        input  i_DM_wen,
        input  i_DM_ren,
        output o_DM_rd,
        output o_timer_irq,
        output o_bus_err
    );

endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane writes plus a memory-mapped
// 64-bit prescaled timer with compare interrupt.
//   i_clk  : sole clock, all state updates on the rising edge
//   i_rst  : synchronous active-high reset (RAM contents are preserved)
//   dm     : bus slave port (address, write data/enables, read enable,
//            read data, timer irq level, unmapped-access error pulse)
// MMIO window (32 bytes at MMIO_BASE): 0x00 MTIME_LO, 0x04 MTIME_HI,
// 0x08 CMP_LO, 0x0C CMP_HI, 0x10 CTRL {PRESC[15:8], EN[0]},
// 0x14 STATUS {PEND[0], write-1-to-clear}, 0x18/0x1C reserved.
module data_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    data_mem_responder_if.slave  dm
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    logic [31:0] mem [MEM_WORDS];

    logic [63:0] mtime, mtime_nxt;
    logic [63:0] cmp, cmp_nxt;
    logic        en, en_nxt;
    logic [7:0]  presc, presc_nxt;
    logic [7:0]  presc_cnt, presc_cnt_nxt;
    logic        pend, pend_nxt;
    logic        bus_err, bus_err_nxt;

    logic          wr;
    logic          access;
    logic          ram_hit;
    logic          mmio_hit;
    logic          wr_ram;
    logic          wr_mmio;
    logic [AW-1:0] ram_idx;
    logic [2:0]    mmio_off;
    logic          tick;
    logic          pend_set;
    logic          pend_clr;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        for (int n = 0; n < 4; n++) begin
            res[8*n +: 8] = wen[n] ? wd[8*n +: 8] : old[8*n +: 8];
        end
        return res;
    endfunction

    // Address decode; RAM takes precedence should the windows ever overlap.
    always_comb begin
        wr       = |dm.i_DM_wen;
        access   = dm.i_DM_ren | wr;
        ram_hit  = {1'b0, dm.i_DM_addr} < RAM_BYTES;
        mmio_hit = !ram_hit && (dm.i_DM_addr[31:5] == MMIO_BASE[31:5]);
        ram_idx  = dm.i_DM_addr[AW+1:2];
        mmio_off = dm.i_DM_addr[4:2];
        wr_ram   = wr && ram_hit;
        wr_mmio  = wr && mmio_hit;
    end

    // Same-cycle read from registered state, so a coincident write returns old data.
    always_comb begin
        dm.o_DM_rd = '0;
        if (dm.i_DM_ren) begin
            if (ram_hit) begin
                dm.o_DM_rd = mem[ram_idx];
            end else if (mmio_hit) begin
                case (mmio_off)
                    OFF_MTIME_LO: dm.o_DM_rd = mtime[31:0];
                    OFF_MTIME_HI: dm.o_DM_rd = mtime[63:32];
                    OFF_CMP_LO:   dm.o_DM_rd = cmp[31:0];
                    OFF_CMP_HI:   dm.o_DM_rd = cmp[63:32];
                    OFF_CTRL:     dm.o_DM_rd = {16'h0, presc, 7'h0, en};
                    OFF_STATUS:   dm.o_DM_rd = {31'h0, pend};
                    default:      dm.o_DM_rd = '0;
                endcase
            end
        end
    end

    // Timer next state. The increment is computed first and register writes
    // overlay it, so a written half wins while the other half keeps the
    // incremented value (including the LO->HI carry).
    always_comb begin
        tick          = en && (presc_cnt == presc);
        mtime_nxt     = mtime + 64'(tick);
        presc_cnt_nxt = presc_cnt;
        if (en) begin
            presc_cnt_nxt = tick ? 8'd0 : presc_cnt + 8'd1;
        end
        cmp_nxt   = cmp;
        en_nxt    = en;
        presc_nxt = presc;
        pend_set  = en && (mtime >= cmp);
        pend_clr  = 1'b0;

        if (wr_mmio) begin
            case (mmio_off)
                OFF_MTIME_LO: mtime_nxt[31:0]  = lane_merge(mtime_nxt[31:0], dm.i_DM_wd, dm.i_DM_wen);
                OFF_MTIME_HI: mtime_nxt[63:32] = lane_merge(mtime_nxt[63:32], dm.i_DM_wd, dm.i_DM_wen);
                OFF_CMP_LO:   cmp_nxt[31:0]    = lane_merge(cmp[31:0], dm.i_DM_wd, dm.i_DM_wen);
                OFF_CMP_HI:   cmp_nxt[63:32]   = lane_merge(cmp[63:32], dm.i_DM_wd, dm.i_DM_wen);
                OFF_CTRL: begin
                    if (dm.i_DM_wen[0]) en_nxt    = dm.i_DM_wd[0];
                    if (dm.i_DM_wen[1]) presc_nxt = dm.i_DM_wd[15:8];
                    presc_cnt_nxt = 8'd0;
                end
                OFF_STATUS:   pend_clr = dm.i_DM_wen[0] & dm.i_DM_wd[0];
                default: ;
            endcase
        end

        // Set beats write-1-to-clear when both happen in the same cycle.
        pend_nxt    = pend_set | (pend & ~pend_clr);
        bus_err_nxt = access && !ram_hit && !mmio_hit;
    end

    // Timer, status and error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime     <= '0;
            cmp       <= '1;
            en        <= 1'b0;
            presc     <= 8'd0;
            presc_cnt <= 8'd0;
            pend      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            cmp       <= cmp_nxt;
            en        <= en_nxt;
            presc     <= presc_nxt;
            presc_cnt <= presc_cnt_nxt;
            pend      <= pend_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

    // RAM is not reset; writes coincident with reset are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_ram) begin
            mem[ram_idx] <= lane_merge(mem[ram_idx], dm.i_DM_wd, dm.i_DM_wen);
        end
    end

    assign dm.o_timer_irq = pend;
    assign dm.o_bus_err   = bus_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios with hand-computed
// constants, then randomized traffic compared against a behavioural model.
module tb_data_mem_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] MMIO      = 32'h1000_0000;
    localparam logic [31:0] A_MTL     = MMIO + 32'h00;
    localparam logic [31:0] A_MTH     = MMIO + 32'h04;
    localparam logic [31:0] A_CMPL    = MMIO + 32'h08;
    localparam logic [31:0] A_CMPH    = MMIO + 32'h0C;
    localparam logic [31:0] A_CTRL    = MMIO + 32'h10;
    localparam logic [31:0] A_STAT    = MMIO + 32'h14;
    localparam logic [31:0] A_BAD     = 32'h2000_0000;

    localparam int K_RAM  = 0;
    localparam int K_MMIO = 1;
    localparam int K_NONE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if dm_if ();

    data_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .MMIO_BASE (MMIO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .dm    (dm_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_ram   [MEM_WORDS];
    bit          m_ram_v [MEM_WORDS];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [7:0]  m_presc;
    logic [7:0]  m_phase;
    logic        m_pend;
    logic        m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int classify(input logic [31:0] a);
        if (a < 32'(MEM_WORDS * 4)) return K_RAM;
        if ((a & 32'hFFFF_FFE0) == (MMIO & 32'hFFFF_FFE0)) return K_MMIO;
        return K_NONE;
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = {64{1'b1}};
        m_en    = 1'b0;
        m_presc = 8'd0;
        m_phase = 8'd0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic re,
                                               output bit known);
        int unsigned idx;
        known = 1'b1;
        if (!re) return 32'h0;
        case (classify(a))
            K_RAM: begin
                idx   = (a >> 2) % MEM_WORDS;
                known = m_ram_v[idx];
                return m_ram[idx];
            end
            K_MMIO: begin
                case ((a - MMIO) >> 2)
                    0: return m_mtime[31:0];
                    1: return m_mtime[63:32];
                    2: return m_cmp[31:0];
                    3: return m_cmp[63:32];
                    4: return {16'h0, m_presc, 7'h0, m_en};
                    5: return {31'h0, m_pend};
                    default: return 32'h0;
                endcase
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] w, input logic re);
        logic [63:0] n_mtime;
        logic [7:0]  n_phase;
        logic [31:0] ctrl_w;
        logic        set;
        logic        clr;
        int          kind;
        int unsigned idx;
        if (r) begin
            model_reset();
            return;
        end
        kind    = classify(a);
        set     = m_en && (m_mtime >= m_cmp);
        clr     = 1'b0;
        n_mtime = m_mtime;
        n_phase = m_phase;
        // MTIME advances once every PRESC+1 enabled cycles
        if (m_en) begin
            if (m_phase == m_presc) begin
                n_mtime = m_mtime + 64'd1;
                n_phase = 8'd0;
            end else begin
                n_phase = m_phase + 8'd1;
            end
        end
        m_err = (re || (w != 4'h0)) && (kind == K_NONE);
        if (w != 4'h0 && kind == K_RAM) begin
            idx          = (a >> 2) % MEM_WORDS;
            m_ram[idx]   = lanes(m_ram[idx], d, w);
            m_ram_v[idx] = m_ram_v[idx] || (w == 4'hF);
        end else if (w != 4'h0 && kind == K_MMIO) begin
            case ((a - MMIO) >> 2)
                0: n_mtime[31:0]  = lanes(n_mtime[31:0], d, w);
                1: n_mtime[63:32] = lanes(n_mtime[63:32], d, w);
                2: m_cmp[31:0]    = lanes(m_cmp[31:0], d, w);
                3: m_cmp[63:32]   = lanes(m_cmp[63:32], d, w);
                4: begin
                    ctrl_w  = lanes({16'h0, m_presc, 7'h0, m_en}, d, w) & 32'h0000_FF01;
                    m_en    = ctrl_w[0];
                    m_presc = ctrl_w[15:8];
                    n_phase = 8'd0;
                end
                5: clr = w[0] && d[0];
                default: ;
            endcase
        end
        m_mtime = n_mtime;
        m_phase = n_phase;
        m_pend  = set || (m_pend && !clr);
    endtask

    // One bus cycle: drive, check comb read, clock, check registered outputs.
    task automatic do_cycle(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] w, input logic re, output logic [31:0] rd_seen);
        logic [31:0] exp_rd;
        bit          known;
        rst             = r;
        dm_if.i_DM_addr = a;
        dm_if.i_DM_wd   = d;
        dm_if.i_DM_wen  = w;
        dm_if.i_DM_ren  = re;
        #2;
        rd_seen = dm_if.o_DM_rd;
        exp_rd  = model_read(a, re, known);
        if (known) check("rd_model", rd_seen, exp_rd);
        model_step(r, a, d, w, re);
        @(posedge clk);
        #1;
        check("irq_model", dm_if.o_timer_irq, m_pend);
        check("bus_err_model", dm_if.o_bus_err, m_err);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] v;
        do_cycle(1'b0, a, d, w, 1'b0, v);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        do_cycle(1'b0, a, 32'h0, 4'h0, 1'b1, v);
    endtask

    task automatic idle();
        logic [31:0] v;
        do_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, v);
    endtask

    initial begin
        logic [31:0] v;
        int          n;

        rst             = 1'b1;
        dm_if.i_DM_addr = 32'h0;
        dm_if.i_DM_wd   = 32'h0;
        dm_if.i_DM_wen  = 4'h0;
        dm_if.i_DM_ren  = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) m_ram_v[i] = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        do_cycle(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, v);
        check("reset_irq", dm_if.o_timer_irq, 1'b0);
        check("reset_bus_err", dm_if.o_bus_err, 1'b0);

        // Reset values of the register file
        rd(A_MTL, v);  check("reset_mtime_lo", v, 32'h0);
        rd(A_CMPL, v); check("reset_cmp_lo", v, 32'hFFFF_FFFF);
        rd(A_CMPH, v); check("reset_cmp_hi", v, 32'hFFFF_FFFF);
        rd(A_CTRL, v); check("reset_ctrl", v, 32'h0);
        rd(A_STAT, v); check("reset_status", v, 32'h0);

        // Initialise the RAM region used below
        for (int i = 0; i < 16; i++) wr(32'h40 + 32'(i * 4), $urandom, 4'hF);

        // Byte-lane write
        wr(32'h40, 32'hAABB_CCDD, 4'hF);
        wr(32'h40, 32'h0011_0000, 4'b0100);
        rd(32'h40, v); check("ram_lane2", v, 32'hAA11_CCDD);

        // Read and write of the same word in one cycle returns old data
        wr(32'h44, 32'h1234_5678, 4'hF);
        do_cycle(1'b0, 32'h46, 32'hDEAD_BEEF, 4'hF, 1'b1, v);
        check("ram_rw_old", v, 32'h1234_5678);
        rd(32'h44, v); check("ram_rw_new", v, 32'hDEAD_BEEF);

        // Prescale 3: one tick every 4 cycles
        wr(A_CTRL, 32'h0000_0301, 4'hF);
        repeat (40) idle();
        rd(A_MTL, v); check("presc3_40cyc", v, 32'd10);
        rd(A_CTRL, v); check("ctrl_readback", v, 32'h0000_0301);

        // LO->HI carry and write priority over increment
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_MTL, 32'hFFFF_FFFF, 4'hF);
        wr(A_MTH, 32'h0, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        rd(A_MTL, v); check("carry_lo_before", v, 32'hFFFF_FFFF);
        rd(A_MTH, v); check("carry_hi", v, 32'd1);
        rd(A_MTL, v); check("carry_lo_after", v, 32'd1);
        wr(A_MTL, 32'd5, 4'hF);
        rd(A_MTL, v); check("wr_priority_lo", v, 32'd5);
        rd(A_MTH, v); check("wr_priority_hi", v, 32'd1);

        // Compare interrupt, set-wins W1C, then clear
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_MTL, 32'h0, 4'hF);
        wr(A_MTH, 32'h0, 4'hF);
        wr(A_CMPH, 32'h0, 4'hF);
        wr(A_CMPL, 32'd20, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        n = 0;
        while (!dm_if.o_timer_irq && n < 100) begin
            idle();
            n++;
        end
        check("irq_rise_cycles", 64'(n), 64'd21);
        wr(A_STAT, 32'h1, 4'h1);
        check("irq_set_wins", dm_if.o_timer_irq, 1'b1);
        wr(A_CMPL, 32'd1000, 4'hF);
        wr(A_STAT, 32'h1, 4'h1);
        check("irq_w1c_low", dm_if.o_timer_irq, 1'b0);

        // Unmapped accesses
        rd(A_BAD, v);
        check("bad_rd_zero", v, 32'h0);
        check("bad_rd_err", dm_if.o_bus_err, 1'b1);
        idle();
        check("bad_err_one_cycle", dm_if.o_bus_err, 1'b0);
        wr(A_BAD, 32'hFFFF_FFFF, 4'hF);
        check("bad_wr_err", dm_if.o_bus_err, 1'b1);
        rd(32'h40, v); check("bad_wr_ram_intact", v, 32'hAA11_CCDD);
        rd(A_CMPL, v); check("bad_wr_cmp_intact", v, 32'd1000);

        // Reset with EN=1 and PEND=1, mid prescale count
        wr(A_CMPL, 32'h0, 4'hF);
        wr(A_CTRL, 32'h0000_0301, 4'hF);
        idle();
        idle();
        check("pre_reset_irq", dm_if.o_timer_irq, 1'b1);
        do_cycle(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0, v);
        check("reset_irq_low", dm_if.o_timer_irq, 1'b0);
        do_cycle(1'b1, A_BAD, 32'h0, 4'h0, 1'b1, v);
        check("reset_no_bus_err", dm_if.o_bus_err, 1'b0);
        rd(A_MTL, v);  check("rst_mtime_lo", v, 32'h0);
        rd(A_MTH, v);  check("rst_mtime_hi", v, 32'h0);
        rd(A_CMPL, v); check("rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd(A_CMPH, v); check("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd(32'h40, v); check("rst_ram_kept", v, 32'hAA11_CCDD);
        wr(A_CTRL, 32'h0000_0301, 4'hF);
        repeat (3) idle();
        rd(A_MTL, v); check("presc_restart_0", v, 32'd0);
        rd(A_MTL, v); check("presc_restart_1", v, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  w;
            logic        re;
            logic        r;
            int unsigned sel;
            int unsigned off;
            sel = $urandom_range(0, 9);
            d   = $urandom;
            if (sel < 4) begin
                a = 32'h40 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end else if (sel < 8) begin
                off = $urandom_range(0, 7);
                a   = MMIO + 32'(off * 4) + 32'($urandom_range(0, 3));
                if (off == 4) begin
                    d = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 1))};
                end else if (off < 4 && $urandom_range(0, 1) == 1) begin
                    d = 32'($urandom_range(0, 200));
                end else if (off == 5) begin
                    d = 32'($urandom_range(0, 1));
                end
            end else begin
                a = (sel == 8) ? ($urandom | 32'h8000_0000) : (MMIO + 32'h20 + 32'($urandom_range(0, 255)));
            end
            w  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            re = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 299) == 0);
            do_cycle(r, a, d, w, re, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
